// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the alu_seq_acc accumulator ALU.
//   - op-code localparams OP_ADD..OP_MUL
//   - flag bit indices inside the 4-bit {V,C,N,Z} flag word
//   - FSM state encoding
//   - pack_flags(): assembles a flag word from its four bits
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_ACC = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;
  localparam int FLG_V = 3;

  typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

  function automatic logic [3:0] pack_flags(input logic v, input logic c,
                                            input logic n, input logic z);
    logic [3:0] f;
    f        = '0;
    f[FLG_V] = v;
    f[FLG_C] = c;
    f[FLG_N] = n;
    f[FLG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_shift_add_mul.sv
// alu_shift_add_mul: iterative unsigned shift-add multiplier, one multiplier
// bit per cycle, WIDTH cycles per product.
//   clk, rst  clock, async active-low reset
//   load      capture a/b and start iterating (next WIDTH cycles)
//   a, b      multiplicand / multiplier
//   abort     stop iterating; product is discarded
//   product   full 2*WIDTH product, valid while last=1 (includes the final step)
//   last      high during the final iteration cycle
module alu_shift_add_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               abort,
  output logic [2*WIDTH-1:0] product,
  output logic               last
);
  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] r_mcand, r_prod, w_prod_nxt;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_run;

  // Product including the current step, so the owner can capture the final
  // result on the same edge as the last iteration.
  assign w_prod_nxt = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
  assign product    = w_prod_nxt;
  assign last       = r_run && (r_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mcand  <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
    end else if (abort) begin
      r_run <= 1'b0;
    end else if (load) begin
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_prod   <= '0;
      r_cnt    <= CW'(WIDTH - 1);
      r_run    <= 1'b1;
    end else if (r_run) begin
      r_prod   <= w_prod_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - 1'b1;
      if (last) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq_acc.sv
// alu_seq_acc: parameterised accumulator ALU with start/busy/done handshake.
//   clk, rst    clock, async active-low reset
//   a_in/a_load operand A register load (IDLE only)
//   b_in, op    operand B and op code, used on an accepted start
//   start       request; accepted when idle and acc_clr=0
//   acc_clr     clear acc/flags, aborts a running multiply
//   busy        multiply in progress
//   done        one-cycle pulse when acc_out/flags were written
//   acc_out     accumulator
//   flags       {V,C,N,Z}
//   op_err      one-cycle pulse on an unsupported op
// Build option: define ALU_MUL_EN to include the iterative multiplier; without
// it, op 111 only raises op_err and busy stays 0.
module alu_seq_acc
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_in,
  input  logic             a_load,
  input  logic [WIDTH-1:0] b_in,
  input  logic [2:0]       op,
  input  logic             start,
  input  logic             acc_clr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] acc_out,
  output logic [3:0]       flags,
  output logic             op_err
);
  logic [WIDTH-1:0] r_a, r_acc;
  logic [3:0]       r_flags;
  logic             r_done, r_err;
  logic             w_idle, w_accept;

`ifdef ALU_MUL_EN
  state_t             r_state;
  logic               r_busy;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_last;

  assign w_idle = (r_state == ST_IDLE);
  assign busy   = r_busy;

  alu_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .load    (w_accept && (op == OP_MUL)),
    .a       (r_a),
    .b       (b_in),
    .abort   (acc_clr && (r_state == ST_MUL)),
    .product (w_prod),
    .last    (w_last)
  );
`else
  assign w_idle = 1'b1;
  assign busy   = 1'b0;
`endif

  assign w_accept = start && w_idle && !acc_clr;

  // Shared adder: SUB is A + ~B + 1, ACC adds B to the accumulator.
  logic [WIDTH-1:0] w_x, w_y, w_res;
  logic             w_cin, w_c, w_v;
  logic [WIDTH:0]   w_sum, w_shl;

  always_comb begin
    w_x   = r_a;
    w_y   = b_in;
    w_cin = 1'b0;
    case (op)
      OP_SUB: begin w_y = ~b_in; w_cin = 1'b1; end
      OP_ACC: w_x = r_acc;
      default: ;
    endcase
  end

  assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
  // The extra top bit catches the last bit shifted out (0 for amount 0).
  assign w_shl = {1'b0, r_a} << b_in[SH_W-1:0];

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_ACC: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);
      end
      OP_XOR: w_res = r_a ^ b_in;
      OP_AND: w_res = r_a & b_in;
      OP_OR:  w_res = r_a | b_in;
      OP_SHL: begin
        w_res = w_shl[WIDTH-1:0];
        w_c   = w_shl[WIDTH];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a     <= '0;
      r_acc   <= '0;
      r_flags <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
`ifdef ALU_MUL_EN
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      // The datapath above already read the old A for any op accepted here.
      if (a_load && w_idle) r_a <= a_in;
      if (acc_clr) begin
        r_acc   <= '0;
        r_flags <= '0;
`ifdef ALU_MUL_EN
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
`endif
      end else if (w_accept) begin
        if (op == OP_MUL) begin
`ifdef ALU_MUL_EN
          r_state <= ST_MUL;
          r_busy  <= 1'b1;
`else
          r_err   <= 1'b1;
`endif
        end else begin
          r_acc   <= w_res;
          r_flags <= pack_flags(w_v, w_c, w_res[WIDTH-1], ~|w_res);
          r_done  <= 1'b1;
        end
      end
`ifdef ALU_MUL_EN
      else if ((r_state == ST_MUL) && w_last) begin
        r_acc   <= w_prod[WIDTH-1:0];
        r_flags <= pack_flags(1'b0, |w_prod[2*WIDTH-1:WIDTH],
                              w_prod[WIDTH-1], ~|w_prod[WIDTH-1:0]);
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end
`endif
    end
  end

  assign acc_out = r_acc;
  assign flags   = r_flags;
  assign done    = r_done;
  assign op_err  = r_err;

endmodule
